// File: rtl/SECDED_ECC_pkg.sv
// Shared types for the SECDED error logger: event classification and the
// per-error record queued for software or the scrub controller.
package SECDED_ECC_pkg;

    localparam int ECC_SYND_W = 8;
    localparam int ECC_ADDR_W = 32;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        CE   = 2'd1,
        UE   = 2'd2
    } ecc_evt_e;

    // Address tags wider than ECC_ADDR_W are truncated into the record.
    typedef struct packed {
        logic [ECC_ADDR_W-1:0] addr;
        logic [ECC_SYND_W-1:0] syndrome;
        logic                  is_ue;
    } ecc_err_rec_t;

    // A double error outranks a single error on the same word.
    function automatic ecc_evt_e ecc_classify(input logic valid,
                                              input logic single_err,
                                              input logic double_err);
        if (!valid)     return NONE;
        if (double_err) return UE;
        if (single_err) return CE;
        return NONE;
    endfunction

endpackage

// File: rtl/ecc_log_fifo.sv
// Synchronous FIFO of error records; extra pointer MSB tells full from empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module ecc_log_fifo
    import SECDED_ECC_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  ecc_err_rec_t push_rec,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output ecc_err_rec_t head
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    ecc_err_rec_t     mem_q [DEPTH];
    ecc_err_rec_t     mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                  (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        head    = mem_q[rd_ptr_q[IDX_W-1:0]];

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q[IDX_W-1:0]] = push_rec;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the head is masked by the top while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/ecc_error_logger.sv
// CE/UE statistics, level interrupts and error-record log behind a valid/ready port.
// ECC_LOG_FIFO_EN selects the LOG_DEPTH-entry FIFO; otherwise a first-error capture register.
module ecc_error_logger
    import SECDED_ECC_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int CNT_W     = 16,
    parameter int LOG_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [ADDR_W-1:0]     in_addr,
    input  logic [ECC_SYND_W-1:0] in_syndrome,
    input  logic                  in_single_error,
    input  logic                  in_double_error,
    input  logic [CNT_W-1:0]      ce_threshold,
    input  logic                  clear,
    input  logic                  irq_ack,
    output logic [CNT_W-1:0]      ce_count,
    output logic [CNT_W-1:0]      ue_count,
    output logic                  ce_irq,
    output logic                  ue_irq,
    output logic                  log_valid,
    input  logic                  log_ready,
    output logic [ADDR_W-1:0]     log_addr,
    output logic [ECC_SYND_W-1:0] log_syndrome,
    output logic                  log_is_ue,
    output logic                  log_overflow
);

    ecc_evt_e         evt;
    ecc_err_rec_t     push_rec;
    ecc_err_rec_t     head_rec;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic             ce_hit;
    logic [CNT_W-1:0] ce_count_q, ce_count_d;
    logic [CNT_W-1:0] ue_count_q, ue_count_d;
    logic             ce_irq_q, ce_irq_d;
    logic             ue_irq_q, ue_irq_d;
    logic             overflow_q, overflow_d;

    always_comb begin
        evt = clear ? NONE : ecc_classify(in_valid, in_single_error, in_double_error);
        push              = (evt != NONE);
        push_rec.addr     = ECC_ADDR_W'(in_addr);
        push_rec.syndrome = in_syndrome;
        push_rec.is_ue    = (evt == UE);
        pop               = !empty && log_ready;

        ce_count_d = ce_count_q;
        ue_count_d = ue_count_q;
        if (clear) begin
            ce_count_d = '0;
            ue_count_d = '0;
        end else begin
            if (evt == CE && ce_count_q != '1) ce_count_d = ce_count_q + CNT_W'(1);
            if (evt == UE && ue_count_q != '1) ue_count_d = ue_count_q + CNT_W'(1);
        end

        // Threshold is compared against the post-increment count.
        ce_hit = (evt == CE) && (ce_threshold != '0) && (ce_count_d >= ce_threshold);

        if (clear)        ce_irq_d = 1'b0;
        else if (ce_hit)  ce_irq_d = 1'b1;
        else if (irq_ack) ce_irq_d = 1'b0;
        else              ce_irq_d = ce_irq_q;

        if (clear)            ue_irq_d = 1'b0;
        else if (evt == UE)   ue_irq_d = 1'b1;
        else if (irq_ack)     ue_irq_d = 1'b0;
        else                  ue_irq_d = ue_irq_q;

        if (clear)                      overflow_d = 1'b0;
        else if (push && full && !pop)  overflow_d = 1'b1;
        else                            overflow_d = overflow_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ce_count_q <= '0;
            ue_count_q <= '0;
            ce_irq_q   <= 1'b0;
            ue_irq_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            ce_count_q <= ce_count_d;
            ue_count_q <= ue_count_d;
            ce_irq_q   <= ce_irq_d;
            ue_irq_q   <= ue_irq_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef ECC_LOG_FIFO_EN
    ecc_log_fifo #(
        .DEPTH(LOG_DEPTH)
    ) u_log_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (clear),
        .push     (push),
        .push_rec (push_rec),
        .pop      (pop),
        .full     (full),
        .empty    (empty),
        .head     (head_rec)
    );
`else
    logic         cap_valid_q, cap_valid_d;
    ecc_err_rec_t cap_rec_q, cap_rec_d;
    logic [31:0]  unused_log_depth;

    assign unused_log_depth = 32'(LOG_DEPTH);

    // Behaves as a one-deep log: a pop frees the slot for a same-cycle push.
    always_comb begin
        cap_valid_d = cap_valid_q;
        cap_rec_d   = cap_rec_q;
        if (clear) begin
            cap_valid_d = 1'b0;
        end else begin
            if (pop) cap_valid_d = 1'b0;
            if (push && (!cap_valid_q || pop)) begin
                cap_valid_d = 1'b1;
                cap_rec_d   = push_rec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_valid_q <= 1'b0;
            cap_rec_q   <= '0;
        end else begin
            cap_valid_q <= cap_valid_d;
            cap_rec_q   <= cap_rec_d;
        end
    end

    assign full     = cap_valid_q;
    assign empty    = !cap_valid_q;
    assign head_rec = cap_rec_q;
`endif

    assign ce_count     = ce_count_q;
    assign ue_count     = ue_count_q;
    assign ce_irq       = ce_irq_q;
    assign ue_irq       = ue_irq_q;
    assign log_overflow = overflow_q;
    assign log_valid    = !empty;
    assign log_addr     = empty ? '0 : ADDR_W'(head_rec.addr);
    assign log_syndrome = empty ? '0 : head_rec.syndrome;
    assign log_is_ue    = !empty && head_rec.is_ue;

endmodule

// File: tb/tb_ecc_error_logger.sv
// Directed and randomized bench for ecc_error_logger against a queue-based model;
// the model depth follows ECC_LOG_FIFO_EN (LOG_DEPTH entries, else a single slot).
module tb_ecc_error_logger;

    localparam int ADDR_W    = 32;
    localparam int CNT_W     = 4;
    localparam int LOG_DEPTH = 8;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;
`ifdef ECC_LOG_FIFO_EN
    localparam int M_DEPTH = LOG_DEPTH;
`else
    localparam int M_DEPTH = 1;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [ADDR_W-1:0] in_addr;
    logic [7:0]        in_syndrome;
    logic              in_single_error;
    logic              in_double_error;
    logic [CNT_W-1:0]  ce_threshold;
    logic              clear;
    logic              irq_ack;
    logic [CNT_W-1:0]  ce_count;
    logic [CNT_W-1:0]  ue_count;
    logic              ce_irq;
    logic              ue_irq;
    logic              log_valid;
    logic              log_ready;
    logic [ADDR_W-1:0] log_addr;
    logic [7:0]        log_syndrome;
    logic              log_is_ue;
    logic              log_overflow;

    ecc_error_logger #(
        .ADDR_W    (ADDR_W),
        .CNT_W     (CNT_W),
        .LOG_DEPTH (LOG_DEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_addr         (in_addr),
        .in_syndrome     (in_syndrome),
        .in_single_error (in_single_error),
        .in_double_error (in_double_error),
        .ce_threshold    (ce_threshold),
        .clear           (clear),
        .irq_ack         (irq_ack),
        .ce_count        (ce_count),
        .ue_count        (ue_count),
        .ce_irq          (ce_irq),
        .ue_irq          (ue_irq),
        .log_valid       (log_valid),
        .log_ready       (log_ready),
        .log_addr        (log_addr),
        .log_syndrome    (log_syndrome),
        .log_is_ue       (log_is_ue),
        .log_overflow    (log_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned addr;
        int unsigned synd;
        bit          is_ue;
    } rec_t;

    rec_t mq[$];
    int   m_ce, m_ue;
    bit   m_ce_irq, m_ue_irq, m_ovf;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Applies the rules to the inputs present at the edge just taken.
    task automatic model_edge();
        bit popped, ev_ce, ev_ue;
        rec_t r;
        if (!rst_n || clear) begin
            m_ce = 0; m_ue = 0; m_ce_irq = 0; m_ue_irq = 0; m_ovf = 0;
            mq.delete();
        end else begin
            popped = (mq.size() > 0) && log_ready;
            ev_ue  = in_valid && in_double_error;
            ev_ce  = in_valid && !in_double_error && in_single_error;
            if (popped) void'(mq.pop_front());
            if (ev_ce && m_ce < CNT_MAX) m_ce++;
            if (ev_ue && m_ue < CNT_MAX) m_ue++;
            if (ev_ce && ce_threshold != 0 && m_ce >= int'(ce_threshold)) m_ce_irq = 1;
            else if (irq_ack) m_ce_irq = 0;
            if (ev_ue) m_ue_irq = 1;
            else if (irq_ack) m_ue_irq = 0;
            if (ev_ce || ev_ue) begin
                if (mq.size() < M_DEPTH) begin
                    r.addr = in_addr; r.synd = in_syndrome; r.is_ue = ev_ue;
                    mq.push_back(r);
                end else begin
                    m_ovf = 1;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("ce_count", ce_count, m_ce);
        chk("ue_count", ue_count, m_ue);
        chk("ce_irq", ce_irq, m_ce_irq);
        chk("ue_irq", ue_irq, m_ue_irq);
        chk("log_overflow", log_overflow, m_ovf);
        chk("log_valid", log_valid, mq.size() != 0);
        chk("log_addr", log_addr, mq.size() != 0 ? mq[0].addr : 0);
        chk("log_syndrome", log_syndrome, mq.size() != 0 ? mq[0].synd : 0);
        chk("log_is_ue", log_is_ue, mq.size() != 0 ? mq[0].is_ue : 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input bit v, input bit s, input bit d,
                         input int unsigned a, input int unsigned syn);
        in_valid        = v;
        in_single_error = s;
        in_double_error = d;
        in_addr         = a;
        in_syndrome     = 8'(syn);
    endtask

    task automatic do_clear();
        drive(0, 0, 0, 0, 0);
        clear = 1;
        tick();
        clear = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned a3[3];
        int unsigned s3[3];
        int unsigned last_addr;
        int drained;

        a3[0] = 'h10; a3[1] = 'h20; a3[2] = 'h30;
        s3[0] = 'h07; s3[1] = 'h0B; s3[2] = 'h0D;

        // Reset held two cycles with a live event on the inputs
        rst_n = 0; clear = 0; irq_ack = 0; log_ready = 0; ce_threshold = 0;
        drive(1, 1, 0, 'hABCD, 'h55);
        #2;
        tick();
        tick();
        chk("rst_ce_count", ce_count, 0);
        chk("rst_log_valid", log_valid, 0);
        rst_n = 1;
        drive(0, 0, 0, 0, 0);
        tick();

        // CE threshold of 3, then in-order drain
        ce_threshold = 3;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, a3[i], s3[i]);
            tick();
            if (i == 1) chk("thr_irq_before", ce_irq, 0);
        end
        chk("thr_irq_after", ce_irq, 1);
        chk("thr_ce_count", ce_count, 3);
        drive(0, 0, 0, 0, 0);
        log_ready = 1;
        for (int i = 0; i < 3 && i < M_DEPTH; i++) begin
            chk("thr_drain_addr", log_addr, a3[i]);
            chk("thr_drain_synd", log_syndrome, s3[i]);
            chk("thr_drain_is_ue", log_is_ue, 0);
            tick();
        end
        chk("thr_drained", log_valid, 0);

        // UE precedence over CE
        do_clear();
        drive(1, 1, 1, 'h44, 'h03);
        tick();
        drive(0, 0, 0, 0, 0);
        chk("ue_count", ue_count, 1);
        chk("ue_ce_count", ce_count, 0);
        chk("ue_irq", ue_irq, 1);
        chk("ue_rec_is_ue", log_is_ue, 1);
        tick();
        chk("ue_one_record", log_valid, 0);

        // Overflow with consumer stalled
        do_clear();
        log_ready = 0;
        for (int i = 0; i < 9; i++) begin
            drive(1, 1, 0, 'h100 + i * 4, i);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        chk("ovf_flag", log_overflow, 1);
        chk("ovf_ce_count", ce_count, 9);
        log_ready = 1;
        for (int i = 0; i < M_DEPTH; i++) begin
            chk("ovf_drain_addr", log_addr, 'h100 + i * 4);
            tick();
        end
        chk("ovf_drained", log_valid, 0);

        // Saturation, ack-vs-set and clear-vs-event priority
        do_clear();
        for (int i = 0; i < 17; i++) begin
            drive(1, 1, 0, 'h300 + i, 'h11);
            tick();
        end
        chk("sat_ce_count", ce_count, 'hF);
        irq_ack = 1;
        tick();
        chk("ack_set_wins", ce_irq, 1);
        drive(0, 0, 0, 0, 0);
        tick();
        irq_ack = 0;
        chk("ack_clears", ce_irq, 0);
        drive(1, 0, 1, 'h555, 'h21);
        clear = 1;
        tick();
        clear = 0;
        drive(0, 0, 0, 0, 0);
        chk("clr_ue_count", ue_count, 0);
        chk("clr_ue_irq", ue_irq, 0);
        chk("clr_log_valid", log_valid, 0);

        // Push and pop together while full
        log_ready = 0;
        for (int i = 0; i < M_DEPTH; i++) begin
            drive(1, 1, 0, 'h200 + i, i);
            tick();
        end
        drive(1, 1, 0, 'h2FF, 'h7E);
        log_ready = 1;
        tick();
        drive(0, 0, 0, 0, 0);
        chk("full_pp_no_ovf", log_overflow, 0);
        drained = 0;
        last_addr = 0;
        for (int i = 0; i < M_DEPTH + 4; i++) begin
            if (log_valid) begin
                last_addr = log_addr;
                drained++;
            end
            tick();
        end
        chk("full_pp_occupancy", drained, M_DEPTH);
        chk("full_pp_last_out", last_addr, 'h2FF);

        // Randomized traffic, including clears, acks and mid-drain resets
        do_clear();
        for (int n = 0; n < 600; n++) begin
            if (n % 150 == 0) ce_threshold = 4'($urandom_range(0, 6));
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 4) == 0, $urandom, $urandom_range(0, 255));
            log_ready = $urandom_range(0, 2) != 0;
            irq_ack   = $urandom_range(0, 15) == 0;
            clear     = $urandom_range(0, 63) == 0;
            rst_n     = $urandom_range(0, 199) != 0;
            tick();
        end
        rst_n = 1; clear = 0; irq_ack = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
